// File: rtl/mul16_seq_pkg.sv
// Shared ALU definitions for the sequential multiplier: widths and state encoding.
package mul16_seq_pkg;

    localparam int MUL_W = 16;
    localparam int MUL_CNT_W = $clog2(MUL_W + 1);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul16_seq_mul_step.sv
// One shift-and-add iteration: conditionally add mag_a to the upper half, then shift right
// with the adder carry entering the MSB.  Kept standalone so a pipelined variant can chain copies.
module mul_step
    import mul16_seq_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag_a,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    always_comb begin
        addend   = acc[0] ? {1'b0, mag_a} : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        acc_next = {sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul16_seq.sv
// Iterative WIDTH x WIDTH multiplier, unsigned or two's-complement, one multiplier bit per clock.
// Fixed latency: done pulses 17 clocks after the edge that accepts start.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   MUL_IDLE | waiting for start; operands captured as magnitudes on accept
//   MUL_RUN  | one add/shift per edge, WIDTH iterations
//   MUL_FIX  | apply result sign, load product, pulse done
module mul16_seq
    import mul16_seq_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_t         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [CNT_W-1:0]   count;
    logic               neg;

    // Truncated negation: |0x8000| stays 0x8000 and is then treated as unsigned.
    always_comb begin
        mag_a_in = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b_in = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    mul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .mag_a   (mag_a),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MUL_IDLE;
            acc     <= '0;
            mag_a   <= '0;
            count   <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mag_a <= mag_a_in;
                        acc   <= {{WIDTH{1'b0}}, mag_b_in};
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count <= '0;
                        busy  <= 1'b1;
                        state <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= MUL_FIX;
                    end
                end
                MUL_FIX: begin
                    product <= neg ? (~acc + 1'b1) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= MUL_IDLE;
                end
                default: begin
                    state <= MUL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
